charlie7x5_scan: RTL and testbench
==================================

Name: charlie7x5_scan

Overview:
- Scan controller for the 7-pin charlieplexed 7x5 LED matrix behind the board's tri-state SB_IO cells; drives their output enables and output data.
- Holds a double-buffered 7x5 framebuffer and walks one anode row per time slot, with a blanking gap between rows against ghosting.
- Sits between `top` logic (writes pixels, commits frames) and the `charlie7x5_oe` / `charlie7x5_o` pins.

Parameters:
- TICKS_PER_ROW, 13714, clk cycles per row slot (48 MHz / (7*500 Hz)); must be > BLANK_TICKS+1.
- BLANK_TICKS, 48, cycles at the start of each slot with all pins released.

Ports:
- clk  in  1  system clock (48 MHz HFOSC).
- rst_n  in  1  reset; asynchronous, active-low.
- wr_en  in  1  write strobe, one pixel row per cycle.
- wr_row  in  3  back-buffer row index 0..6; 7 is ignored.
- wr_data  in  5  column bits; bit c = column c lit.
- commit  in  1  single-cycle pulse: request back-to-front copy at next frame boundary.
- pending  out  1  commit requested, not yet applied.
- frame_sync  out  1  one-cycle pulse at start of each frame.
- charlie7x5_oe  out  7  per-pin output enable; 0 = hi-Z.
- charlie7x5_o  out  7  per-pin output level.

Behaviour:
- Reset (async on rst_n low):
  - row=0, tick=0.
  - front and back buffers all 0.
  - pending=0, frame_sync=0, oe=0, o=0.
- Counters:
  - tick counts 0..TICKS_PER_ROW-1, then wraps to 0 and row advances.
  - row counts 0..6, then wraps to 0.
- Pin mapping for row r, column c:
  - anode pin = r.
  - cathode pin = c if c<r, else c+1.
- Pin drive, per (row, tick) state:
  - tick < BLANK_TICKS: oe=0, o=0.
  - tick >= BLANK_TICKS:
    - anode: oe=1, o=1.
    - lit column's cathode: oe=1, o=0.
    - all other pins: oe=0, o=0.
  - Anode is asserted even when the row is all dark.
- Output timing: oe, o and frame_sync are registered; they reflect the (row, tick) state of the previous cycle (1-cycle latency).
- frame_sync: high for the one cycle that follows state row=0, tick=0.
- Writes:
  - When wr_en=1 and wr_row<=6, back[wr_row] takes wr_data on the same edge.
  - Writes never touch front.
- Commit and swap:
  - commit sets pending.
  - Swap point: state row=6, tick=TICKS_PER_ROW-1. On that edge, if pending=1: front<=back and pending clears.
  - The new frame is first displayed on row 0.
- Boundary cases:
  - Write on the swap edge: the copy takes the pre-write back value; the write still lands in back.
  - Commit on the swap edge: pending stays 1, so the next frame swaps again.
  - Commit while pending=1: no extra effect.
  - rst_n low mid-frame: all pins go hi-Z immediately (async); after release, scanning restarts at row 0, tick 0.
- Safety invariant: at most one pin is driven high at any time. Verification asserts this every cycle.

Optional Feature:
- Macro: CHARLIE7X5_DIM_EN.
- With the macro:
  - Adds input port dim[3:0].
  - A 4-bit pwm counter free-runs, +1 every clk, reset 0.
  - dim is sampled at tick 0 of each row.
  - During the active window, anode and cathodes are driven only while pwm <= dim_sampled; otherwise all pins are released as in blanking.
  - dim=15 gives full on; dim=0 gives 1/16 duty.
- Without the macro: no dim port; the active window is always fully driven.

Test Plan (TICKS_PER_ROW=16, BLANK_TICKS=2):
1. Reset, then release rst_n.
   - oe=0, o=0 for the first 3 cycles.
   - frame_sync pulses on cycle 1.
   - pending=0.
2. Write row 3 = 5'b10101, pulse commit, wait for the swap.
   - Row 3 active cycles: oe=7'b0101101, o=7'b0001000.
   - pending clears exactly at the row 6 → row 0 wrap.
3. Write row 3 = 5'b11111 without commit.
   - Display is unchanged.
   - Row 3 still shows the step 2 pattern.
4. Drive wr_en and commit on the swap edge, with a new value for row 0.
   - Front gets the old row 0 value.
   - pending remains 1.
   - Next frame shows the new value.
5. Assert rst_n low at row 4, tick 9.
   - oe=0 asynchronously.
   - After release: scan restarts at row 0 and buffers read 0.
   - Over a full random run, no cycle has two pins with oe=1 and o=1.
6. CHARLIE7X5_DIM_EN, dim=3, row 0 lit.
   - Within the active window, driven cycles are exactly those where pwm is 0..3.

Source files
------------

// File: rtl/charlie7x5_scan_if.sv
// charlie7x5_scan_if: pixel-write / commit bus between top logic and the scanner.
// master = top logic (writes rows, commits); slave = charlie7x5_scan.
interface charlie7x5_scan_if;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [4:0] wr_data;
    logic       commit;
    logic       pending;
    logic       frame_sync;

    modport master (
        output wr_en, wr_row, wr_data, commit,
        input  pending, frame_sync
    );

    modport slave (
        input  wr_en, wr_row, wr_data, commit,
        output pending, frame_sync
    );
endinterface

// File: rtl/charlie7x5_scan.sv
// charlie7x5_scan: double-buffered 7x5 charlieplex scanner, one anode row per slot.
// Ports: clk, rst_n (async low), bus (write/commit/pending/frame_sync), pin oe/o; dim if CHARLIE7X5_DIM_EN.
module charlie7x5_scan #(
    parameter int TICKS_PER_ROW = 13714,
    parameter int BLANK_TICKS   = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    charlie7x5_scan_if.slave      bus,
`ifdef CHARLIE7X5_DIM_EN
    input  logic [3:0]            dim,
`endif
    output logic [6:0]            charlie7x5_oe,
    output logic [6:0]            charlie7x5_o
);
    localparam int TW = (TICKS_PER_ROW > 1) ? $clog2(TICKS_PER_ROW) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_ROW - 1);
    localparam logic [TW-1:0] TICK_ON   = TW'(BLANK_TICKS);

    logic [2:0]      r_row;
    logic [TW-1:0]   r_tick;
    logic [6:0][4:0] r_front;
    logic [6:0][4:0] r_back;
    logic            r_pending;
    logic            r_fsync;
    logic [6:0]      r_oe;
    logic [6:0]      r_o;

    logic            w_row_end;
    logic            w_swap;
    logic            w_gate;
    logic            w_on;
    logic [4:0]      w_lit;
    logic [6:0]      w_anode;
    logic [6:0]      w_low;
    logic [6:0]      w_cath;
    logic [6:0]      w_oe;
    logic [6:0]      w_o;

    assign w_row_end = (r_tick == TICK_LAST);
    assign w_swap    = w_row_end && (r_row == 3'd6);

`ifdef CHARLIE7X5_DIM_EN
    logic [3:0] r_pwm;
    logic [3:0] r_dim;
    logic [3:0] w_dim;

    // Use the live input on tick 0 so the sample applies to its own row.
    assign w_dim  = (r_tick == '0) ? dim : r_dim;
    assign w_gate = (r_pwm <= w_dim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= '0;
            r_dim <= '0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
            if (r_tick == '0) r_dim <= dim;
        end
    end
`else
    assign w_gate = 1'b1;
`endif

    // Columns below the anode keep their pin index; the rest shift up by one.
    always_comb begin
        w_lit   = r_front[r_row];
        w_anode = 7'b1 << r_row;
        w_low   = w_anode - 7'd1;
        w_cath  = ({2'b00, w_lit} & w_low)
                | ({1'b0, w_lit, 1'b0} & ~(w_low | w_anode));
        w_on    = (r_tick >= TICK_ON) && w_gate;
        w_oe    = '0;
        w_o     = '0;
        if (w_on) begin
            w_oe = w_anode | w_cath;
            w_o  = w_anode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row     <= '0;
            r_tick    <= '0;
            r_front   <= '0;
            r_back    <= '0;
            r_pending <= 1'b0;
            r_fsync   <= 1'b0;
            r_oe      <= '0;
            r_o       <= '0;
        end else begin
            if (w_row_end) begin
                r_tick <= '0;
                r_row  <= (r_row == 3'd6) ? 3'd0 : r_row + 3'd1;
            end else begin
                r_tick <= r_tick + 1'b1;
            end

            // Copy sees back before any same-edge write.
            if (w_swap && r_pending) r_front <= r_back;

            if (bus.wr_en && (bus.wr_row != 3'd7))
                r_back[bus.wr_row] <= bus.wr_data;

            // A commit on the swap edge survives for the next frame.
            r_pending <= bus.commit | (r_pending & ~w_swap);

            r_fsync <= (r_row == 3'd0) && (r_tick == '0);
            r_oe    <= w_oe;
            r_o     <= w_o;
        end
    end

    assign bus.pending    = r_pending;
    assign bus.frame_sync = r_fsync;
    assign charlie7x5_oe  = r_oe;
    assign charlie7x5_o   = r_o;
endmodule

// File: tb/tb_charlie7x5_scan.sv
// tb_charlie7x5_scan: directed + random checks of charlie7x5_scan against a pixel-level model.
// Define CHARLIE7X5_DIM_EN to build and check the dimming variant.
module tb_charlie7x5_scan;
    localparam int TPR   = 16;
    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] oe;
    logic [6:0] o;
`ifdef CHARLIE7X5_DIM_EN
    logic [3:0] dim = 4'd3;
`endif

    charlie7x5_scan_if bus ();

    charlie7x5_scan #(
        .TICKS_PER_ROW (TPR),
        .BLANK_TICKS   (BLANK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
`ifdef CHARLIE7X5_DIM_EN
        .dim           (dim),
`endif
        .charlie7x5_oe (oe),
        .charlie7x5_o  (o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int         m_row, m_tick, m_pwm, m_dim, m_last_pwm;
    logic [4:0] m_front [7];
    logic [4:0] m_back  [7];
    bit         m_pend;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_tick = 0; m_pend = 0;
        m_pwm = 0; m_dim = 0; m_last_pwm = 0;
        for (int i = 0; i < 7; i++) begin
            m_front[i] = '0;
            m_back[i]  = '0;
        end
    endtask

    function automatic void exp_pins(input int r, input int t,
                                     input logic [4:0] lit, input bit gate,
                                     output logic [6:0] eo, output logic [6:0] ev);
        eo = '0;
        ev = '0;
        if (t >= BLANK && gate) begin
            eo[r] = 1'b1;
            ev[r] = 1'b1;
            for (int c = 0; c < 5; c++)
                if (lit[c]) eo[(c < r) ? c : c + 1] = 1'b1;
        end
    endfunction

    // One clock: predict outputs from the pre-edge model state, then compare.
    task automatic cyc();
        logic [6:0] e_oe, e_o;
        bit         e_fs, gate;
        int         dused, hi;
        e_oe = '0; e_o = '0; e_fs = 0;
        if (rst_n) begin
            dused = 15;
`ifdef CHARLIE7X5_DIM_EN
            dused = (m_tick == 0) ? int'(dim) : m_dim;
            if (m_tick == 0) m_dim = int'(dim);
`endif
            gate = (m_pwm <= dused);
            exp_pins(m_row, m_tick, m_front[m_row], gate, e_oe, e_o);
            e_fs = (m_row == 0 && m_tick == 0);
            if (m_row == 6 && m_tick == TPR - 1 && m_pend) begin
                for (int i = 0; i < 7; i++) m_front[i] = m_back[i];
                m_pend = bus.commit;
            end else begin
                m_pend = m_pend | bus.commit;
            end
            if (bus.wr_en && bus.wr_row < 7) m_back[bus.wr_row] = bus.wr_data;
            m_last_pwm = m_pwm;
            m_pwm = (m_pwm + 1) % 16;
            if (m_tick == TPR - 1) begin
                m_tick = 0;
                m_row  = (m_row + 1) % 7;
            end else begin
                m_tick++;
            end
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
        chk("oe", 32'(oe), 32'(e_oe));
        chk("o", 32'(o), 32'(e_o));
        chk("frame_sync", 32'(bus.frame_sync), 32'(e_fs));
        chk("pending", 32'(bus.pending), 32'(m_pend));
        hi = $countones(oe & o);
        chk("safety", 32'(hi <= 1), 32'd1);
    endtask

    task automatic run_to(input int r, input int t);
        int n = 0;
        while (!(m_row == r && m_tick == t) && n < 2000) begin
            cyc();
            n++;
        end
        chk("run_to_timeout", 32'(n < 2000), 32'd1);
    endtask

    task automatic idle_bus();
        bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0; bus.commit = 1'b0;
    endtask

    initial begin
        idle_bus();
        model_reset();
        // 1: reset, then release
        #12;
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        cyc();
        rst_n = 1'b1;
        chk("c0_oe", 32'(oe), 32'd0);
        cyc();
        chk("c1_fsync", 32'(bus.frame_sync), 32'd1);
        chk("c1_oe", 32'(oe), 32'd0);
        cyc();
        chk("c2_oe", 32'(oe), 32'd0);

        // 2: write row 3, commit, swap
        bus.wr_en = 1'b1; bus.wr_row = 3'd3; bus.wr_data = 5'b10101;
        bus.commit = 1'b1;
        cyc();
        idle_bus();
        run_to(6, TPR - 1);
        chk("pend_before_wrap", 32'(bus.pending), 32'd1);
        cyc();
        chk("pend_after_wrap", 32'(bus.pending), 32'd0);
        run_to(3, 6);
`ifndef CHARLIE7X5_DIM_EN
        chk("row3_oe", 32'(oe), 32'b0101101);
        chk("row3_o", 32'(o), 32'b0001000);
`endif

        // 3: write without commit leaves display alone
        bus.wr_en = 1'b1; bus.wr_row = 3'd3; bus.wr_data = 5'b11111;
        cyc();
        idle_bus();
        run_to(3, 6);
        run_to(3, 7);
`ifndef CHARLIE7X5_DIM_EN
        chk("row3_hold_oe", 32'(oe), 32'b0101101);
`endif
        chk("row3_hold_pend", 32'(bus.pending), 32'd0);

        // 4: write + commit on the swap edge
        bus.wr_en = 1'b1; bus.wr_row = 3'd0; bus.wr_data = 5'b00110;
        bus.commit = 1'b1;
        cyc();
        idle_bus();
        run_to(6, TPR - 1);
        bus.wr_en = 1'b1; bus.wr_row = 3'd0; bus.wr_data = 5'b11001;
        bus.commit = 1'b1;
        cyc();
        idle_bus();
        chk("swap_commit_pend", 32'(bus.pending), 32'd1);
        run_to(0, 6);
`ifndef CHARLIE7X5_DIM_EN
        chk("row0_old_oe", 32'(oe), 32'b0001101);
`endif
        run_to(6, TPR - 1);
        cyc();
        chk("pend_clear2", 32'(bus.pending), 32'd0);
        run_to(0, 6);
`ifndef CHARLIE7X5_DIM_EN
        chk("row0_new_oe", 32'(oe), 32'b0110011);
`endif

        // random traffic
        for (int i = 0; i < 7 * TPR * 6; i++) begin
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_row  = 3'($urandom_range(0, 7));
            bus.wr_data = 5'($urandom);
            bus.commit  = ($urandom_range(0, 19) == 0);
            cyc();
        end
        idle_bus();

`ifdef CHARLIE7X5_DIM_EN
        // 6: dim gating in row 0 with the whole row lit
        bus.wr_en = 1'b1; bus.wr_row = 3'd0; bus.wr_data = 5'b11111;
        bus.commit = 1'b1;
        cyc();
        idle_bus();
        run_to(0, BLANK + 1);
        for (int i = 0; i < TPR - BLANK - 1; i++) begin
            cyc();
            chk("dim_gate", 32'(oe != 0), 32'(m_last_pwm <= 3));
        end
`endif

        // 5: async reset mid-frame
        run_to(4, 9);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_oe", 32'(oe), 32'd0);
        chk("async_o", 32'(o), 32'd0);
        chk("async_pend", 32'(bus.pending), 32'd0);
        model_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("restart_fsync", 32'(bus.frame_sync), 32'd1);
        run_to(3, 6);
`ifndef CHARLIE7X5_DIM_EN
        chk("cleared_oe", 32'(oe), 32'b0001000);
`endif
        run_to(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
